// File: rtl/fl_checkpoint_stack.sv
// Branch checkpoint stack: holds one free-list snapshot per in-flight branch and
// replays it to FreddyList on a mispredict. Live snapshots absorb retiring T_old regs.
module fl_checkpoint_stack #(
  parameter int N               = 2,
  parameter int PHYS_REGS       = 64,
  parameter int DEPTH           = 8,
  parameter int TAG_W           = $clog2(DEPTH),
  parameter int PHYS_REG_IDX    = $clog2(PHYS_REGS),
  parameter int NUM_SCALAR_BITS = $clog2(N + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push_valid,
  input  logic [PHYS_REGS-1:0]       push_free_list,
  output logic [TAG_W-1:0]           push_tag,
  output logic                       full,
  output logic [TAG_W:0]             free_entries,
  input  logic                       resolve_valid,
  input  logic [TAG_W-1:0]           resolve_tag,
  input  logic                       resolve_mispredict,
  input  logic [PHYS_REG_IDX-1:0]    phys_regs_retiring [N],
  input  logic [NUM_SCALAR_BITS-1:0] num_retiring_valid,
  output logic                       restore_flag,
  output logic [PHYS_REGS-1:0]       free_list_restore,
  output logic [TAG_W-1:0]           restore_tag
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W + 1)'(DEPTH);

  // Pointers carry a wrap bit above the index so full and empty are distinguishable.
  logic [TAG_W:0]       r_head;
  logic [TAG_W:0]       r_tail;
  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_resolved;
  logic [PHYS_REGS-1:0] r_snap [DEPTH];

  logic [TAG_W-1:0]     w_head_idx;
  logic [TAG_W-1:0]     w_tail_idx;
  logic [TAG_W:0]       w_used;
  logic [PHYS_REGS-1:0] w_retiring_list;
  logic                 w_res_hit;
  logic                 w_mispredict;
  logic                 w_correct;
  logic                 w_push;
  logic                 w_pop;
  logic [TAG_W:0]       w_tag_ptr;
  logic [TAG_W:0]       w_squash_cnt;
  logic [DEPTH-1:0]     w_squash;
  logic [DEPTH-1:0]     w_valid_nxt;
  logic [DEPTH-1:0]     w_resolved_nxt;

  assign w_head_idx   = r_head[TAG_W-1:0];
  assign w_tail_idx   = r_tail[TAG_W-1:0];
  assign w_used       = r_tail - r_head;
  assign full         = (w_tail_idx == w_head_idx) && (r_tail[TAG_W] != r_head[TAG_W]);
  assign free_entries = DEPTH_CNT - w_used;
  assign push_tag     = w_tail_idx;

  assign w_res_hit    = resolve_valid && r_valid[resolve_tag];
  assign w_mispredict = w_res_hit && resolve_mispredict;
  assign w_correct    = w_res_hit && !resolve_mispredict;
  // A mispredicting branch squashes anything dispatched behind it, including this cycle's push.
  assign w_push       = push_valid && !full && !w_mispredict;
  assign w_pop        = r_valid[w_head_idx] && r_resolved[w_head_idx] &&
                        !(w_mispredict && (resolve_tag == w_head_idx));

  // Rebuild the full pointer for the squashed tag: it sits behind the tail, so if its
  // index is not below the tail index the tail has wrapped past it.
  assign w_tag_ptr    = {(resolve_tag < w_tail_idx) ? r_tail[TAG_W] : ~r_tail[TAG_W], resolve_tag};
  assign w_squash_cnt = r_tail - w_tag_ptr;

  // NOTE: always_comb uses blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    w_retiring_list = '0;
    for (int i = 0; i < N; i++) begin
      if (NUM_SCALAR_BITS'(i) < num_retiring_valid)
        w_retiring_list[phys_regs_retiring[i]] = 1'b1;
    end
  end

  always_comb begin
    w_squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_squash[i] = w_mispredict && ({1'b0, TAG_W'(i) - resolve_tag} < w_squash_cnt);
    end
  end

  always_comb begin
    w_valid_nxt    = r_valid;
    w_resolved_nxt = r_resolved;
    if (w_push) begin
      w_valid_nxt[w_tail_idx]    = 1'b1;
      w_resolved_nxt[w_tail_idx] = 1'b0;
    end
    if (w_correct)
      w_resolved_nxt[resolve_tag] = 1'b1;
    if (w_pop) begin
      w_valid_nxt[w_head_idx]    = 1'b0;
      w_resolved_nxt[w_head_idx] = 1'b0;
    end
    w_valid_nxt    = w_valid_nxt & ~w_squash;
    w_resolved_nxt = w_resolved_nxt & ~w_squash;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_valid    <= '0;
      r_resolved <= '0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_resolved <= w_resolved_nxt;
      if (w_pop)
        r_head <= r_head + 1'b1;
      if (w_mispredict)
        r_tail <= w_tag_ptr;
      else if (w_push)
        r_tail <= r_tail + 1'b1;
    end
  end

  // NOTE: snapshot storage has no reset; an entry is only read while its valid bit is set.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && (w_tail_idx == TAG_W'(i)))
        r_snap[i] <= push_free_list | w_retiring_list;
      else if (r_valid[i])
        r_snap[i] <= r_snap[i] | w_retiring_list;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      restore_flag      <= 1'b0;
      restore_tag       <= '0;
      free_list_restore <= '0;
    end else begin
      restore_flag <= w_mispredict;
      if (w_mispredict) begin
        restore_tag       <= resolve_tag;
        free_list_restore <= r_snap[resolve_tag] | w_retiring_list;
      end
    end
  end

endmodule

// File: tb/tb_fl_checkpoint_stack.sv
// Directed bench for fl_checkpoint_stack: expected restores go into a queue that a
// monitor drains on each restore_flag pulse; pointer status is checked inline.
module tb_fl_checkpoint_stack;

  localparam int N     = 2;
  localparam int PR    = 64;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PR-1:0]    flist;
  } restore_t;

  logic             clock;
  logic             reset_n;
  logic             push_valid;
  logic [PR-1:0]    push_free_list;
  logic [TAG_W-1:0] push_tag;
  logic             full;
  logic [TAG_W:0]   free_entries;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_mispredict;
  logic [5:0]       retire_regs [N];
  logic [1:0]       num_retiring_valid;
  logic             restore_flag;
  logic [PR-1:0]    free_list_restore;
  logic [TAG_W-1:0] restore_tag;

  restore_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  fl_checkpoint_stack #(.N(N), .PHYS_REGS(PR), .DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .push_valid         (push_valid),
    .push_free_list     (push_free_list),
    .push_tag           (push_tag),
    .full               (full),
    .free_entries       (free_entries),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .phys_regs_retiring (retire_regs),
    .num_retiring_valid (num_retiring_valid),
    .restore_flag       (restore_flag),
    .free_list_restore  (free_list_restore),
    .restore_tag        (restore_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (restore_flag === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_restore: got tag %0d flist 0x%0h expected no pulse",
                 restore_tag, free_list_restore);
      end else begin
        restore_t e;
        e = exp_q.pop_front();
        check("restore_tag", 64'(restore_tag), 64'(e.tag));
        check("free_list_restore", free_list_restore, e.flist);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_op(input logic [PR-1:0] data);
    push_valid     = 1'b1;
    push_free_list = data;
    tick();
    push_valid     = 1'b0;
  endtask

  task automatic resolve_op(input logic [TAG_W-1:0] tag, input logic mp);
    resolve_valid      = 1'b1;
    resolve_tag        = tag;
    resolve_mispredict = mp;
    tick();
    resolve_valid      = 1'b0;
  endtask

  task automatic expect_restore(input logic [TAG_W-1:0] tag, input logic [PR-1:0] fl);
    exp_q.push_back(restore_t'{tag: tag, flist: fl});
  endtask

  // Asserts reset between edges and checks the outputs clear immediately.
  task automatic apply_reset(input string name);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check({name, "_free"}, 64'(free_entries), 64'(DEPTH));
    check({name, "_full"}, 64'(full), 64'd0);
    check({name, "_flag"}, 64'(restore_flag), 64'd0);
    check({name, "_push_tag"}, 64'(push_tag), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n            = 1'b0;
    push_valid         = 1'b0;
    push_free_list     = '0;
    resolve_valid      = 1'b0;
    resolve_tag        = '0;
    resolve_mispredict = 1'b0;
    retire_regs[0]     = '0;
    retire_regs[1]     = '0;
    num_retiring_valid = '0;

    apply_reset("reset");

    // Fill all eight entries, then a push into a full stack must be ignored.
    for (int k = 0; k < DEPTH; k++) begin
      check("fill_push_tag", 64'(push_tag), 64'(k));
      push_op(PR'(1) << k);
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_free", 64'(free_entries), 64'd0);
    push_op(64'hFF00);
    check("overflow_push_tag", 64'(push_tag), 64'd0);
    check("overflow_full", 64'(full), 64'd1);
    check("overflow_free", 64'(free_entries), 64'd0);
    expect_restore(3'd5, 64'h20);
    resolve_op(3'd5, 1'b1);
    check("mp5_free", 64'(free_entries), 64'd3);
    check("mp5_full", 64'(full), 64'd0);
    check("mp5_push_tag", 64'(push_tag), 64'd5);
    expect_restore(3'd0, 64'h01);
    resolve_op(3'd0, 1'b1);
    check("mp0_free", 64'(free_entries), 64'd8);

    // Snapshot absorbs a register retired after the checkpoint; only lowest-index slots count.
    apply_reset("reset2");
    push_op(64'h0F);
    retire_regs[0]     = 6'd20;
    retire_regs[1]     = 6'd30;
    num_retiring_valid = 2'd1;
    tick();
    num_retiring_valid = 2'd0;
    expect_restore(3'd0, 64'h0F | (64'd1 << 20));
    resolve_op(3'd0, 1'b1);
    tick();
    check("restore_flag_one_cycle", 64'(restore_flag), 64'd0);
    check("restore_hold", free_list_restore, 64'h0F | (64'd1 << 20));

    // Registers retiring in the resolve cycle itself also land in the restored list.
    push_op(64'h1000);
    retire_regs[0]     = 6'd40;
    retire_regs[1]     = 6'd41;
    num_retiring_valid = 2'd2;
    expect_restore(3'd0, 64'h1000 | (64'd1 << 40) | (64'd1 << 41));
    resolve_op(3'd0, 1'b1);
    num_retiring_valid = 2'd0;

    // Mispredict in the middle squashes younger entries; later resolve of a squashed tag is ignored.
    apply_reset("reset3");
    push_op(64'h100);
    push_op(64'h200);
    push_op(64'h400);
    expect_restore(3'd1, 64'h200);
    resolve_op(3'd1, 1'b1);
    check("mid_push_tag", 64'(push_tag), 64'd1);
    check("mid_free", 64'(free_entries), 64'd7);
    resolve_op(3'd2, 1'b1);
    resolve_op(3'd2, 1'b0);
    check("stale_free", 64'(free_entries), 64'd7);
    resolve_op(3'd0, 1'b0);
    tick();
    check("stale_pop_free", 64'(free_entries), 64'd8);

    // Out-of-order correct resolves: head waits for tag0, then pops one per edge.
    apply_reset("reset4");
    push_op(64'h1);
    push_op(64'h2);
    resolve_op(3'd1, 1'b0);
    check("ooo_free_a", 64'(free_entries), 64'd6);
    resolve_op(3'd0, 1'b0);
    check("ooo_free_b", 64'(free_entries), 64'd6);
    tick();
    check("ooo_free_c", 64'(free_entries), 64'd7);
    tick();
    check("ooo_free_d", 64'(free_entries), 64'd8);

    // Push together with mispredict of tag0: mispredict wins, push dropped.
    apply_reset("reset5");
    push_op(64'hA0);
    push_op(64'hB0);
    push_op(64'hC0);
    check("pm_push_tag_pre", 64'(push_tag), 64'd3);
    push_valid     = 1'b1;
    push_free_list = 64'hDEAD;
    expect_restore(3'd0, 64'hA0);
    resolve_op(3'd0, 1'b1);
    push_valid     = 1'b0;
    check("pm_push_tag", 64'(push_tag), 64'd0);
    check("pm_free", 64'(free_entries), 64'd8);

    // Pop and push on a full stack in the same cycle: pop happens, push refused.
    apply_reset("reset6");
    for (int k = 0; k < DEPTH; k++) push_op(PR'(1) << (k + 8));
    resolve_op(3'd0, 1'b0);
    check("fp_full_pre", 64'(full), 64'd1);
    push_op(64'hBEEF);
    check("fp_full", 64'(full), 64'd0);
    check("fp_free", 64'(free_entries), 64'd1);
    check("fp_push_tag", 64'(push_tag), 64'd0);
    expect_restore(3'd1, 64'h200);
    resolve_op(3'd1, 1'b1);
    check("fp_after_mp_free", 64'(free_entries), 64'd8);

    // Reset asserted mid-run with live checkpoints.
    push_op(64'h3);
    push_op(64'h5);
    apply_reset("midrun_reset");

    repeat (3) tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
